// File: rtl/i2c_slave.sv
// I2C target: 7-bit addressed byte receiver/transmitter sampling an asynchronous bus on clk.
// SDA is only ever pulled low (open drain); all bus edges come from synchronized copies.
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i2c_scl,
    input  logic       i2c_sda,
    output logic       sda_pull_low,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       busy
);

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StWrite,
        StWriteAck,
        StRead,
        StReadAck
    } state_e;

    // [1:0] are the synchronizer, [2] is the delayed copy for edge detection
    logic [2:0] scl_sync_q, sda_sync_q;
    logic       scl_s, scl_d, sda_s, sda_d;
    logic       scl_rise, scl_fall, start_det, stop_det;

    state_e     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       rw_q, rw_d;
    logic       pull_q, pull_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_req_q, tx_req_d;
    logic       ack_q, ack_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_sync_q <= 3'b111;
            sda_sync_q <= 3'b111;
        end else begin
            scl_sync_q <= {scl_sync_q[1:0], i2c_scl};
            sda_sync_q <= {sda_sync_q[1:0], i2c_sda};
        end
    end

    assign scl_s     = scl_sync_q[1];
    assign scl_d     = scl_sync_q[2];
    assign sda_s     = sda_sync_q[1];
    assign sda_d     = sda_sync_q[2];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & scl_d & ~sda_s & sda_d;
    assign stop_det  = scl_s & scl_d & sda_s & ~sda_d;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        rw_d       = rw_q;
        pull_d     = pull_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_req_d   = 1'b0;
        ack_d      = ack_q;

        if (stop_det) begin
            state_d   = StIdle;
            pull_d    = 1'b0;
            bit_cnt_d = 3'd0;
            ack_d     = 1'b0;
        end else if (start_det) begin
            state_d   = StAddr;
            pull_d    = 1'b0;
            bit_cnt_d = 3'd0;
            ack_d     = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: ;
                StAddr: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            rw_d    = sda_s;
                            state_d = (shift_q[6:0] == SLAVE_ADDR) ? StAddrAck : StIdle;
                        end
                    end
                end
                // First falling edge starts the ACK, the second one ends it.
                StAddrAck: begin
                    if (scl_fall) begin
                        if (!pull_q) begin
                            pull_d = 1'b1;
                        end else if (rw_q) begin
                            shift_d  = tx_data;
                            tx_req_d = 1'b1;
                            pull_d   = ~tx_data[7];
                            state_d  = StRead;
                        end else begin
                            pull_d  = 1'b0;
                            state_d = StWrite;
                        end
                    end
                end
                StWrite: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            rx_data_d  = {shift_q[6:0], sda_s};
                            rx_valid_d = 1'b1;
                            state_d    = StWriteAck;
                        end
                    end
                end
                StWriteAck: begin
                    if (scl_fall) begin
                        if (!pull_q) begin
                            pull_d = 1'b1;
                        end else begin
                            pull_d  = 1'b0;
                            state_d = StWrite;
                        end
                    end
                end
                StRead: begin
                    if (scl_fall) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            pull_d  = 1'b0;
                            state_d = StReadAck;
                        end else begin
                            shift_d = {shift_q[6:0], 1'b0};
                            pull_d  = ~shift_q[6];
                        end
                    end
                end
                // Next byte is fetched on the ACK rise but only driven after SCL falls.
                StReadAck: begin
                    if (scl_rise) begin
                        if (!sda_s) begin
                            shift_d  = tx_data;
                            tx_req_d = 1'b1;
                            ack_d    = 1'b1;
                        end else begin
                            state_d = StIdle;
                        end
                    end else if (scl_fall && ack_q) begin
                        ack_d   = 1'b0;
                        pull_d  = ~shift_q[7];
                        state_d = StRead;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
            rw_q       <= 1'b0;
            pull_q     <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            rw_q       <= rw_d;
            pull_q     <= pull_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_req_q   <= tx_req_d;
            ack_q      <= ack_d;
        end
    end

    assign sda_pull_low = pull_q;
    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign tx_req       = tx_req_q;
    assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: a bus master drives SCL/SDA (10 clk per bit) while a protocol-level
// model predicts the target's SDA drive, busy, and the rx/tx byte traffic.
module tb_i2c_slave;

    localparam logic [6:0] ADDR = 7'h50;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       sda_bus;
    logic       sda_pull_low;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_req;
    logic       busy;

    assign sda_bus = sda_m & ~sda_pull_low;

    always #5 clk = ~clk;

    i2c_slave #(.SLAVE_ADDR(ADDR)) dut (
        .clk         (clk),
        .reset       (reset),
        .i2c_scl     (scl),
        .i2c_sda     (sda_bus),
        .sda_pull_low(sda_pull_low),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_data     (tx_data),
        .tx_req      (tx_req),
        .busy        (busy)
    );

    int n_checks = 0;
    int n_fail = 0;

    // Protocol model state
    logic       exp_pull = 1'b0;
    logic       exp_busy = 1'b0;
    logic [7:0] exp_rx = 8'h00;
    logic [7:0] exp_tx = 8'h00;
    logic       mdl_addr_phase = 1'b0;
    logic       mdl_sel = 1'b0;
    logic       mdl_rd = 1'b0;
    int         mdl_rx_cnt = 0;
    int         mdl_tx_cnt = 0;
    int         dut_rx_cnt = 0;
    int         dut_tx_cnt = 0;
    logic       chk_en = 1'b0;

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, sampled away from the active edge.
    initial begin
        logic prev_scl;
        logic prev_pull;
        int   low_cnt;
        prev_scl = 1'b1;
        prev_pull = 1'b0;
        low_cnt = 0;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                if (!reset) begin
                    check1("rst_pull", sda_pull_low, 1'b0);
                    check1("rst_busy", busy, 1'b0);
                    check1("rst_rx_valid", rx_valid, 1'b0);
                    check1("rst_tx_req", tx_req, 1'b0);
                end else begin
                    if (scl) begin
                        check1("pull_model", sda_pull_low, exp_pull);
                        if (prev_scl) check1("pull_stable_scl_high", sda_pull_low, prev_pull);
                    end
                    if (low_cnt >= 4) check1("busy_model", busy, exp_busy);
                    if (rx_valid) begin
                        dut_rx_cnt++;
                        check8("rx_data_on_valid", rx_data, exp_rx);
                    end
                    if (tx_req) dut_tx_cnt++;
                end
            end
            prev_scl = scl;
            prev_pull = sda_pull_low;
            low_cnt = scl ? 0 : low_cnt + 1;
        end
    end

    initial begin
        #3000000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One SCL period: SDA set 1 clk after SCL fell, sample mid-high, end with SCL low.
    task automatic bit_slot(input logic b, output logic v);
        tick(1);
        sda_m = b;
        tick(4);
        scl = 1'b1;
        tick(2);
        v = sda_bus;
        tick(3);
        scl = 1'b0;
    endtask

    task automatic bus_start();
        tick(1);
        sda_m = 1'b1;
        exp_pull = 1'b0;
        tick(4);
        scl = 1'b1;
        tick(5);
        sda_m = 1'b0;
        exp_busy = 1'b1;
        mdl_addr_phase = 1'b1;
        mdl_sel = 1'b0;
        mdl_rd = 1'b0;
        tick(5);
        scl = 1'b0;
    endtask

    task automatic bus_stop();
        tick(1);
        sda_m = 1'b0;
        exp_pull = 1'b0;
        tick(4);
        scl = 1'b1;
        tick(5);
        sda_m = 1'b1;
        exp_busy = 1'b0;
        mdl_sel = 1'b0;
        tick(5);
    endtask

    task automatic master_write(input logic [7:0] b, output logic ack);
        logic exp_ack;
        logic v;
        if (mdl_addr_phase) exp_ack = (b[7:1] == ADDR);
        else exp_ack = mdl_sel && !mdl_rd;
        if (!mdl_addr_phase && exp_ack) begin
            exp_rx = b;
            mdl_rx_cnt++;
        end
        exp_pull = 1'b0;
        for (int i = 7; i >= 0; i--) bit_slot(b[i], v);
        if (mdl_addr_phase && !exp_ack) exp_busy = 1'b0;
        exp_pull = exp_ack;
        bit_slot(1'b1, v);
        ack = ~v;
        exp_pull = 1'b0;
        if (mdl_addr_phase) begin
            mdl_sel = exp_ack;
            mdl_rd = b[0];
            mdl_addr_phase = 1'b0;
            if (exp_ack && b[0]) begin
                exp_tx = tx_data;
                mdl_tx_cnt++;
            end
        end
    endtask

    // Reads one byte; next_tx is presented before the ACK slot for the following byte.
    task automatic master_read(input logic ack, input logic [7:0] next_tx, output logic [7:0] got);
        logic v;
        for (int i = 7; i >= 0; i--) begin
            exp_pull = (mdl_sel && mdl_rd) ? ~exp_tx[i] : 1'b0;
            bit_slot(1'b1, v);
            got[i] = v;
        end
        tx_data = next_tx;
        exp_pull = 1'b0;
        if (ack && mdl_sel && mdl_rd) begin
            exp_tx = next_tx;
            mdl_tx_cnt++;
        end
        bit_slot(~ack, v);
        if (!ack) begin
            mdl_sel = 1'b0;
            exp_busy = 1'b0;
        end
    endtask

    initial begin
        logic       ack;
        logic       v;
        logic [7:0] got;
        int         rx0;
        int         tx0;

        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        check1("reset_pull", sda_pull_low, 1'b0);
        check1("reset_busy", busy, 1'b0);
        check8("reset_rx_data", rx_data, 8'h00);
        tick(3);
        reset = 1'b1;
        tick(10);

        // Write 0xA0, 0x5C, STOP
        rx0 = dut_rx_cnt;
        bus_start();
        master_write(8'hA0, ack);
        check1("s1_addr_ack", ack, 1'b1);
        master_write(8'h5C, ack);
        check1("s1_data_ack", ack, 1'b1);
        bus_stop();
        tick(5);
        check8("s1_rx_data", rx_data, 8'h5C);
        check_int("s1_rx_pulses", dut_rx_cnt - rx0, 1);
        check1("s1_busy_after_stop", busy, 1'b0);

        // Address 0x51 write: no ACK
        rx0 = dut_rx_cnt;
        bus_start();
        master_write(8'hA2, ack);
        check1("s2_addr_nack", ack, 1'b0);
        check1("s2_busy_idle", busy, 1'b0);
        bus_stop();
        tick(5);
        check_int("s2_rx_pulses", dut_rx_cnt - rx0, 0);

        // Read two bytes, ACK then NACK
        tx0 = dut_tx_cnt;
        tx_data = 8'h3C;
        bus_start();
        master_write(8'hA1, ack);
        check1("s3_addr_ack", ack, 1'b1);
        master_read(1'b1, 8'hC3, got);
        check8("s3_byte0", got, 8'h3C);
        master_read(1'b0, 8'h00, got);
        check8("s3_byte1", got, 8'hC3);
        tick(2);
        check1("s3_busy_after_nack", busy, 1'b0);
        bus_stop();
        tick(5);
        check_int("s3_tx_pulses", dut_tx_cnt - tx0, 2);

        // Write, repeated START, read
        tx_data = 8'h77;
        bus_start();
        master_write(8'hA0, ack);
        check1("s4_addr_ack", ack, 1'b1);
        master_write(8'h12, ack);
        check1("s4_data_ack", ack, 1'b1);
        bus_start();
        master_write(8'hA1, ack);
        check1("s4_raddr_ack", ack, 1'b1);
        master_read(1'b0, 8'h00, got);
        check8("s4_read_byte", got, 8'h77);
        bus_stop();
        tick(5);
        check8("s4_rx_data", rx_data, 8'h12);

        // Reset while the target drives bit 3 of a read byte
        tx_data = 8'h00;
        bus_start();
        master_write(8'hA1, ack);
        check1("s5_addr_ack", ack, 1'b1);
        for (int i = 7; i >= 4; i--) begin
            exp_pull = ~exp_tx[i];
            bit_slot(1'b1, v);
        end
        exp_pull = ~exp_tx[3];
        tick(1);
        sda_m = 1'b1;
        tick(4);
        scl = 1'b1;
        tick(2);
        check1("s5_pull_before_reset", sda_pull_low, 1'b1);
        reset = 1'b0;
        exp_pull = 1'b0;
        #1;
        check1("s5_pull_async_release", sda_pull_low, 1'b0);
        exp_busy = 1'b0;
        mdl_sel = 1'b0;
        mdl_addr_phase = 1'b0;
        tick(3);
        sda_m = 1'b1;
        reset = 1'b1;
        tick(10);
        bus_start();
        master_write(8'hA0, ack);
        check1("s5_post_addr_ack", ack, 1'b1);
        master_write(8'h01, ack);
        check1("s5_post_data_ack", ack, 1'b1);
        bus_stop();
        tick(5);
        check8("s5_rx_data", rx_data, 8'h01);
        check1("s5_busy_after_stop", busy, 1'b0);

        check_int("rx_pulse_total", dut_rx_cnt, mdl_rx_cnt);
        check_int("tx_pulse_total", dut_tx_cnt, mdl_tx_cnt);
        check_int("rx_pulse_total_literal", dut_rx_cnt, 3);
        check_int("tx_pulse_total_literal", dut_tx_cnt, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_slave.md
I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 The block SHALL take parameter SLAVE_ADDR, default 7'h50, which is the 7-bit address the block answers to.
REQ-002 The block SHALL have port clk, input, 1 bit: system clock; all logic is on the rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-004 The block SHALL have port i2c_scl, input, 1 bit: bus SCL, asynchronous to clk.
REQ-005 The block SHALL have port i2c_sda, input, 1 bit: bus SDA level, asynchronous to clk.
REQ-006 The block SHALL have port sda_pull_low, output, 1 bit: open-drain drive; 1 pulls SDA low, 0 releases it.
REQ-007 The block SHALL have port rx_data, output, 8 bits: last byte written by the master.
REQ-008 The block SHALL have port rx_valid, output, 1 bit: one-clk pulse when rx_data is updated.
REQ-009 The block SHALL have port tx_data, input, 8 bits: byte to return on a read.
REQ-010 The block SHALL have port tx_req, output, 1 bit: one-clk pulse when tx_data is sampled.
REQ-011 The block SHALL have port busy, output, 1 bit: high from an addressed START until STOP or release to IDLE.

Function
REQ-012 i2c_scl and i2c_sda SHALL each pass through a 2-FF synchronizer; all edge detection uses the synchronized values plus a third delayed stage.
REQ-013 START SHALL be detected when synced SDA falls while synced SCL is high; STOP when SDA rises while SCL is high.
REQ-014 FSM states: IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK.
REQ-015 START from any state SHALL clear the bit counter and go to ADDR; a repeated START is handled the same way.
REQ-016 STOP from any state SHALL go to IDLE, release sda_pull_low and clear busy.
REQ-017 Data bits SHALL be sampled on the SCL rising edge, MSB first; the 8th ADDR bit is R/W (1 = read).
REQ-018 After 8 ADDR bits: on address match, go to ADDR_ACK and assert sda_pull_low from the next SCL falling edge to the following SCL falling edge; on mismatch, go to IDLE with SDA released.
REQ-019 When ADDR_ACK ends with R/W=0, the FSM SHALL go to WRITE.
REQ-020 When ADDR_ACK ends with R/W=1, the FSM SHALL latch tx_data, pulse tx_req, go to READ, and drive bit 7 on that same falling edge.
REQ-021 WRITE: after 8 bits, the FSM SHALL update rx_data, pulse rx_valid one clk after the 8th rising edge, and go to WRITE_ACK, which drives ACK for one SCL period as in REQ-018; then return to WRITE.
REQ-022 READ: sda_pull_low SHALL equal the inverse of the current shift bit; each bit changes only on an SCL falling edge. After the 8th bit's falling edge, SDA SHALL be released and the FSM goes to READ_ACK.
REQ-023 READ_ACK: on the SCL rise, SDA low (ACK) SHALL trigger a reload of tx_data, a tx_req pulse, and a return to READ at the next falling edge; SDA high (NACK) SHALL go to IDLE.
REQ-024 sda_pull_low SHALL never change while synced SCL is high, except release on STOP or reset.
REQ-025 The bit counter SHALL be 3 bits and wrap 7->0 at each byte boundary.
REQ-026 busy SHALL be high in every state except IDLE.

Reset
REQ-027 While reset=0, the FSM SHALL be held in IDLE with sda_pull_low=0, rx_data=8'h00, rx_valid=0, tx_req=0, busy=0, counter=0, and synchronizer stages =1.
REQ-028 A reset asserted mid-transfer SHALL release SDA immediately (asynchronously); after release, the block ignores the bus until the next START.

Verification
REQ-029 Write 0xA0 then 0x5C, then STOP -> ACK after the address and after the data; rx_data=8'h5C; exactly one rx_valid pulse; busy falls at STOP.
REQ-030 Address 0x51 write -> no ACK (SDA stays high during the 9th clock); FSM in IDLE; no rx_valid.
REQ-031 Read 0xA1 with tx_data=8'h3C; master ACKs, then with tx_data=8'hC3 NACKs, then STOP -> bus bytes 0x3C, 0xC3; two tx_req pulses; FSM in IDLE after NACK.
REQ-032 Write 0xA0 and 0x12, then repeated START, 0xA1, read tx_data=8'h77, NACK, STOP -> rx_data=8'h12; read byte 0x77; no STOP was needed between transfers.
REQ-033 Assert reset while driving bit 3 of a read byte -> sda_pull_low=0 within the same clk; a later full write of 0xA0/0x01 succeeds.
REQ-034 SCL period = 10 clk, with SDA changing 1 clk after SCL falls -> no false START/STOP; sda_pull_low stable throughout every SCL-high phase.
